// File: rtl/vram_dma_write_ctrl.sv
// Burst write sequencer for the CPU-facing VRAM: two 128-bit words per beat, yields to the sync engine.
// Optional stall statistics counter is built when VRAM_DMA_STATS_EN is defined.
module vram_dma_write_ctrl #(
  parameter int ADDR_W    = 12,
  parameter int LEN_W     = 13,
  parameter int TIL_WORDS = 2048,
  parameter int PAT_WORDS = 2048,
  parameter int PAL_WORDS = 64,
  parameter int SPR_WORDS = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_ram,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [255:0]      wr_data,
  output logic [3:0]        ram_sel,
  output logic [ADDR_W-1:0] addr_a,
  output logic [ADDR_W-1:0] addr_b,
  output logic [127:0]      wrdata_a,
  output logic [127:0]      wrdata_b,
  output logic              wren_a,
  output logic              wren_b,
  input  logic              sync_req,
  output logic              sync_gnt,
  output logic              busy,
  output logic              done,
  output logic              cmd_err,
  output logic [31:0]       stall_cycles
);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] cur;
  logic [LEN_W-1:0]  rem;
  logic [LEN_W:0]    cmd_end;
  logic [LEN_W:0]    depth;
  logic              cmd_fire;
  logic              wr_fire;

  // End address is computed one bit wider so an overflowing burst is still caught
  assign cmd_end = {{(LEN_W+1-ADDR_W){1'b0}}, cmd_addr} + {1'b0, cmd_len};

  always_comb begin
    depth = '0;
    case (cmd_ram)
      2'd0:    depth = (LEN_W+1)'(TIL_WORDS);
      2'd1:    depth = (LEN_W+1)'(PAT_WORDS);
      2'd2:    depth = (LEN_W+1)'(PAL_WORDS);
      default: depth = (LEN_W+1)'(SPR_WORDS);
    endcase
  end

  assign cmd_ready = (state == IDLE);
  assign busy      = (state == WRITE);
  assign wr_ready  = (state == WRITE) && !sync_req;
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign wr_fire   = wr_valid && wr_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cur      <= '0;
      rem      <= '0;
      ram_sel  <= '0;
      addr_a   <= '0;
      addr_b   <= '0;
      wrdata_a <= '0;
      wrdata_b <= '0;
      wren_a   <= 1'b0;
      wren_b   <= 1'b0;
      sync_gnt <= 1'b0;
      done     <= 1'b0;
      cmd_err  <= 1'b0;
    end else begin
      wren_a   <= 1'b0;
      wren_b   <= 1'b0;
      done     <= 1'b0;
      cmd_err  <= 1'b0;
      sync_gnt <= sync_req;
      case (state)
        IDLE: begin
          // ram_sel stays valid through the final write cycle, then drops here
          ram_sel <= '0;
          if (cmd_fire) begin
            if (cmd_end > depth) begin
              cmd_err <= 1'b1;
            end else if (cmd_len == '0) begin
              done <= 1'b1;
            end else begin
              state   <= WRITE;
              ram_sel <= 4'b0001 << cmd_ram;
              cur     <= cmd_addr;
              rem     <= cmd_len;
            end
          end
        end
        WRITE: begin
          if (wr_fire) begin
            addr_a   <= cur;
            wrdata_a <= wr_data[127:0];
            wren_a   <= 1'b1;
            // An odd tail only writes port A; the upper half of the beat is dropped
            if (rem >= LEN_W'(2)) begin
              addr_b   <= cur + ADDR_W'(1);
              wrdata_b <= wr_data[255:128];
              wren_b   <= 1'b1;
              cur      <= cur + ADDR_W'(2);
              rem      <= rem - LEN_W'(2);
            end else begin
              rem <= '0;
            end
            if (rem <= LEN_W'(2)) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef VRAM_DMA_STATS_EN
  // Counts cycles a burst is held off by the sync engine; saturating
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (cmd_fire) begin
      stall_cycles <= '0;
    end else if ((state == WRITE) && sync_req && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_vram_dma_write_ctrl.sv
// Randomized scoreboard bench for vram_dma_write_ctrl: expected write events are queued by the
// driver from a word-level burst model and popped by an independent output monitor.
module tb_vram_dma_write_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_ram;
  logic [11:0]  cmd_addr;
  logic [12:0]  cmd_len;
  logic         wr_valid;
  logic         wr_ready;
  logic [255:0] wr_data;
  logic [3:0]   ram_sel;
  logic [11:0]  addr_a;
  logic [11:0]  addr_b;
  logic [127:0] wrdata_a;
  logic [127:0] wrdata_b;
  logic         wren_a;
  logic         wren_b;
  logic         sync_req;
  logic         sync_gnt;
  logic         busy;
  logic         done;
  logic         cmd_err;
  logic [31:0]  stall_cycles;

  vram_dma_write_ctrl dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ram(cmd_ram),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .ram_sel(ram_sel), .addr_a(addr_a), .addr_b(addr_b),
    .wrdata_a(wrdata_a), .wrdata_b(wrdata_b), .wren_a(wren_a), .wren_b(wren_b),
    .sync_req(sync_req), .sync_gnt(sync_gnt), .busy(busy), .done(done),
    .cmd_err(cmd_err), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         err;
    logic         dn;
    logic         wa;
    logic         wb;
    logic [3:0]   sel;
    logic [11:0]  aa;
    logic [11:0]  ab;
    logic [127:0] da;
    logic [127:0] db;
  } exp_t;

  exp_t expQ[$];
  exp_t monItem;
  int   checkCount = 0;
  int   passCount  = 0;
  bit   monitorOn  = 1'b0;
  logic prevSync   = 1'b0;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] req);
    checkCount++;
    if (act === req) passCount++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, req);
  endtask

  function automatic int depthOf(input int r);
    case (r)
      0: return 2048;
      1: return 2048;
      2: return 64;
      default: return 128;
    endcase
  endfunction

  // Monitor: grant follows request by one cycle, and every output event must match the queue head
  always @(negedge clk) begin
    if (monitorOn) begin
      checkOutput("sync_gnt", 128'(sync_gnt), 128'(prevSync));
      prevSync = sync_req;
      if (wren_a || wren_b || done || cmd_err) begin
        checkOutput("wren_while_gnt", 128'(sync_gnt && (wren_a || wren_b)), 128'(0));
        if (expQ.size() == 0) begin
          checkCount++;
          $display("[TB] FAIL unexpected_event: got wren_a=%b wren_b=%b done=%b cmd_err=%b expected none",
                   wren_a, wren_b, done, cmd_err);
        end else begin
          monItem = expQ.pop_front();
          checkOutput("cmd_err", 128'(cmd_err), 128'(monItem.err));
          checkOutput("done", 128'(done), 128'(monItem.dn));
          checkOutput("wren_a", 128'(wren_a), 128'(monItem.wa));
          checkOutput("wren_b", 128'(wren_b), 128'(monItem.wb));
          checkOutput("ram_sel", 128'(ram_sel), 128'(monItem.sel));
          if (monItem.wa) begin
            checkOutput("addr_a", 128'(addr_a), 128'(monItem.aa));
            checkOutput("wrdata_a", wrdata_a, monItem.da);
          end
          if (monItem.wb) begin
            checkOutput("addr_b", 128'(addr_b), 128'(monItem.ab));
            checkOutput("wrdata_b", wrdata_b, monItem.db);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_cmd_ready"}, 128'(cmd_ready), 128'(1));
    checkOutput({tag, "_busy"}, 128'(busy), 128'(0));
    checkOutput({tag, "_wr_ready"}, 128'(wr_ready), 128'(0));
    checkOutput({tag, "_ram_sel"}, 128'(ram_sel), 128'(0));
    checkOutput({tag, "_wren"}, 128'({wren_a, wren_b}), 128'(0));
    checkOutput({tag, "_pulses"}, 128'({done, cmd_err}), 128'(0));
    checkOutput({tag, "_sync_gnt"}, 128'(sync_gnt), 128'(0));
    checkOutput({tag, "_stall"}, 128'(stall_cycles), 128'(0));
  endtask

  function automatic exp_t beatItem(input int ram, input int addr, input int len,
                                    input int beat, input logic [255:0] d);
    exp_t e;
    int   w0;
    w0    = beat * 2;
    e.err = 1'b0;
    e.dn  = (w0 + 2 >= len);
    e.wa  = 1'b1;
    e.wb  = (len - w0 >= 2);
    e.sel = 4'(1 << ram);
    e.aa  = 12'(addr + w0);
    e.ab  = 12'(addr + w0 + 1);
    e.da  = d[127:0];
    e.db  = d[255:128];
    return e;
  endfunction

  // Issue one command and stream its beats; hold keeps wr_valid high with no sync traffic
  task automatic applyStimulus(input int ram, input int addr, input int len,
                               input bit hold, input int syncBeat);
    exp_t         e;
    logic [255:0] d;
    int           beats;
    int           beat;
    int           budget;
    bit           isBurst;
    bit           first;
    isBurst   = 1'b0;
    cmd_valid = 1'b1;
    cmd_ram   = 2'(ram);
    cmd_addr  = 12'(addr);
    cmd_len   = 13'(len);
    @(negedge clk);
    checkOutput("cmd_ready", 128'(cmd_ready), 128'(1));
    e = '{err: 1'b0, dn: 1'b0, wa: 1'b0, wb: 1'b0, sel: 4'd0, aa: 12'd0, ab: 12'd0, da: '0, db: '0};
    if (addr + len > depthOf(ram)) begin
      e.err = 1'b1;
      expQ.push_back(e);
    end else if (len == 0) begin
      e.dn = 1'b1;
      expQ.push_back(e);
    end else begin
      isBurst = 1'b1;
    end
    tick();
    cmd_valid = 1'b0;
    if (!isBurst) begin
      @(negedge clk);
      checkOutput("busy_nonburst", 128'(busy), 128'(0));
      checkOutput("cmd_ready_nonburst", 128'(cmd_ready), 128'(1));
      tick();
      return;
    end
    beats  = (len + 1) / 2;
    beat   = 0;
    budget = 400;
    first  = 1'b1;
    while (beat < beats) begin
      if (beat == syncBeat) begin
        sync_req = 1'b1;
        wr_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          checkOutput("wr_ready_during_sync", 128'(wr_ready), 128'(0));
          tick();
        end
        sync_req = 1'b0;
        syncBeat = -1;
      end
      sync_req = hold ? 1'b0 : ($urandom_range(0, 99) < 15);
      wr_valid = hold ? 1'b1 : ($urandom_range(0, 99) < 75);
      d = {$urandom(), $urandom(), $urandom(), $urandom(),
           $urandom(), $urandom(), $urandom(), $urandom()};
      wr_data = d;
      @(negedge clk);
      if (first) checkOutput("busy_burst", 128'(busy), 128'(1));
      first = 1'b0;
      if (hold) checkOutput("wr_ready_hold", 128'(wr_ready), 128'(1));
      if (wr_valid && wr_ready) begin
        expQ.push_back(beatItem(ram, addr, len, beat, d));
        beat++;
      end
      tick();
      budget--;
      if (budget == 0) begin
        checkCount++;
        $display("[TB] FAIL burst_timeout: got %0d beats expected %0d", beat, beats);
        break;
      end
    end
    wr_valid = 1'b0;
    sync_req = 1'b0;
  endtask

  initial begin
    int   ram;
    int   addr;
    int   len;
    int   dep;
    logic [255:0] d;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_ram   = '0;
    cmd_addr  = '0;
    cmd_len   = '0;
    wr_valid  = 1'b0;
    wr_data   = '0;
    sync_req  = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clk);
    checkIdleOutputs("reset");
    monitorOn = 1'b1;
    tick();

    // Data offered while idle must be refused
    wr_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("wr_ready_idle", 128'(wr_ready), 128'(0));
      tick();
    end
    wr_valid = 1'b0;

    applyStimulus(1, 'h010, 4, 1'b1, -1);
    applyStimulus(0, 'h7FE, 3, 1'b1, -1);
    applyStimulus(2, 0, 3, 1'b1, -1);
    applyStimulus(3, 0, 0, 1'b1, -1);
    applyStimulus(2, 60, 4, 1'b1, -1);
    applyStimulus(2, 61, 4, 1'b1, -1);
    applyStimulus(1, 'h100, 8, 1'b1, 1);
`ifdef VRAM_DMA_STATS_EN
    checkOutput("stall_cycles", 128'(stall_cycles), 128'(5));
`else
    checkOutput("stall_cycles", 128'(stall_cycles), 128'(0));
`endif

    // Reset partway through a burst: no done, outputs cleared, next command runs normally
    cmd_valid = 1'b1;
    cmd_ram   = 2'd0;
    cmd_addr  = 12'h100;
    cmd_len   = 13'd6;
    tick();
    cmd_valid = 1'b0;
    d = {$urandom(), $urandom(), $urandom(), $urandom(),
         $urandom(), $urandom(), $urandom(), $urandom()};
    wr_valid = 1'b1;
    wr_data  = d;
    @(negedge clk);
    checkOutput("wr_ready_prereset", 128'(wr_ready), 128'(1));
    expQ.push_back(beatItem(0, 'h100, 6, 0, d));
    tick();
    wr_valid = 1'b0;
    reset    = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    @(negedge clk);
    checkIdleOutputs("midreset");
    tick();
    applyStimulus(0, 'h100, 6, 1'b1, -1);

    for (int n = 0; n < 40; n++) begin
      ram = $urandom_range(0, 3);
      dep = depthOf(ram);
      if ($urandom_range(0, 4) == 0) begin
        addr = $urandom_range(0, dep - 1);
        len  = dep - addr + $urandom_range(1, 4);
      end else begin
        len  = $urandom_range(0, 17);
        addr = $urandom_range(0, dep - len);
      end
      applyStimulus(ram, addr, len, 1'b0, -1);
    end

    repeat (4) tick();
    checkOutput("queue_drained", 128'(expQ.size()), 128'(0));
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
